ram_ctrl: RTL and testbench

RAM_CTRL -- requirements
Module: ram_ctrl

---
 rtl/ram_ctrl.sv | 119 +++++++++++
 tb/tb_ram_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_ctrl.sv
// Byte-strobed single-clock RAM controller that zero-fills the array after reset or clr.
// Define RAM_FWD_EN so a same-address read returns the word being written in that cycle.
module ram_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    wen,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    ren,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rvalid,
    output logic                    ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   mergedWord;
    logic [DATA_WIDTH-1:0]   readWord;
    logic                    fwdHit;

    // Old word with strobed lanes replaced; written back whole, so a zero strobe rewrites the old value.
    always_comb begin
        mergedWord = mem[waddr];
        for (int i = 0; i < LANES; i++) begin
            if (wstrb[i]) begin
                mergedWord[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

`ifdef RAM_FWD_EN
    assign fwdHit = wen && (waddr == raddr);
`else
    assign fwdHit = 1'b0;
`endif

    assign readWord = fwdHit ? mergedWord : mem[raddr];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        case (state_q)
            INIT: begin
                if (clr) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                    if (cnt_q == LastAddr) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (ren) begin
                    rdata_d  = readWord;
                    rvalid_d = 1'b1;
                end
                // Accesses in the clr cycle still complete before the refill starts.
                if (clr) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // The array has no reset; its contents are only defined once the zero-fill has swept it.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem[cnt_q] <= '0;
        end else if (wen) begin
            mem[waddr] <= mergedWord;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign ready  = (state_q == RUN);

endmodule

// File: tb/tb_ram_ctrl.sv
// Self-checking bench for ram_ctrl: scenario tasks compared against an array model of the memory.
module tb_ram_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clr;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [3:0]    wstrb;
    logic          ren;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          ready;

    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] modelRdata;
    bit            fwd;

    ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .wen   (wen),
        .waddr (waddr),
        .wdata (wdata),
        .wstrb (wstrb),
        .ren   (ren),
        .raddr (raddr),
        .rdata (rdata),
        .rvalid(rvalid),
        .ready (ready)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        clr   = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        wstrb = 4'h0;
    endtask

    task automatic countToReady(output int n);
        n = 0;
        while (!ready && n < 100) begin
            cycle();
            n++;
        end
    endtask

    task automatic zeroModel();
        for (int a = 0; a < DEPTH; a++) model[a] = '0;
    endtask

    // A strobed write keeps unstrobed bytes of the old word and takes strobed bytes from the new data.
    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                            input logic [3:0] strb);
        logic [DW-1:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (old & ~mask) | (data & mask);
    endfunction

    task automatic test_reset();
        int n;
        idle();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
        vectors++;
        if (rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 0", ready); end
        cycle();
        rst_n = 1'b1;
        countToReady(n);
        vectors++;
        if (n != 16) begin miscompares++; $display("[TB] FAIL reset_init_len: got %0d cycles expected 16", n); end
        zeroModel();
        modelRdata = '0;
    endtask

    task automatic test_read_all(input string name);
        for (int i = 0; i < DEPTH; i++) begin
            ren   = 1'b1;
            raddr = AW'(i);
            cycle();
            modelRdata = model[i];
            vectors++;
            if (rvalid !== 1'b1 || rdata !== modelRdata) begin
                miscompares++;
                $display("[TB] FAIL %s_addr%0d: got rvalid=%b rdata=%h expected 1 %h", name, i, rvalid, rdata, modelRdata);
            end
        end
        ren = 1'b0;
        cycle();
        vectors++;
        if (rvalid !== 1'b0 || rdata !== modelRdata) begin
            miscompares++;
            $display("[TB] FAIL %s_hold: got rvalid=%b rdata=%h expected 0 %h", name, rvalid, rdata, modelRdata);
        end
    endtask

    task automatic test_strobe();
        idle();
        wen = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF; wstrb = 4'b1111;
        cycle();
        model[3] = merge(model[3], wdata, wstrb);
        wdata = 32'h11223344; wstrb = 4'b0101;
        cycle();
        model[3] = merge(model[3], wdata, wstrb);
        idle();
        ren = 1'b1; raddr = 4'd3;
        cycle();
        ren = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 32'hDE22BE44) begin
            miscompares++;
            $display("[TB] FAIL strobe_read: got rvalid=%b rdata=%h expected 1 de22be44", rvalid, rdata);
        end
        modelRdata = model[3];
        cycle();
        vectors++;
        if (rvalid !== 1'b0 || rdata !== 32'hDE22BE44) begin
            miscompares++;
            $display("[TB] FAIL strobe_pulse: got rvalid=%b rdata=%h expected 0 de22be44", rvalid, rdata);
        end
    endtask

    task automatic test_same_addr();
        logic [DW-1:0] exp;
        exp = fwd ? 32'hAABBCCDD : model[5];
        idle();
        wen = 1'b1; waddr = 4'd5; wdata = 32'hAABBCCDD; wstrb = 4'hF;
        ren = 1'b1; raddr = 4'd5;
        cycle();
        model[5] = 32'hAABBCCDD;
        wen = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== exp) begin
            miscompares++;
            $display("[TB] FAIL same_addr_rw: got rvalid=%b rdata=%h expected 1 %h", rvalid, rdata, exp);
        end
        cycle();
        ren = 1'b0;
        modelRdata = 32'hAABBCCDD;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 32'hAABBCCDD) begin
            miscompares++;
            $display("[TB] FAIL same_addr_next: got rvalid=%b rdata=%h expected 1 aabbccdd", rvalid, rdata);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] exp;
        logic          expValid;
        idle();
        for (int i = 0; i < 80; i++) begin
            wen   = 1'($urandom_range(0, 1));
            ren   = 1'($urandom_range(0, 1));
            waddr = AW'($urandom);
            raddr = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom);
            wdata = $urandom;
            wstrb = 4'($urandom);
            expValid = ren;
            exp = (fwd && wen && waddr == raddr) ? merge(model[waddr], wdata, wstrb) : model[raddr];
            if (wen) model[waddr] = merge(model[waddr], wdata, wstrb);
            if (ren) modelRdata = exp;
            cycle();
            vectors++;
            if (rvalid !== expValid || rdata !== modelRdata) begin
                miscompares++;
                $display("[TB] FAIL random_%0d: got rvalid=%b rdata=%h expected %b %h", i, rvalid, rdata, expValid, modelRdata);
            end
        end
        idle();
        cycle();
    endtask

    task automatic test_back_to_back();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            wen = 1'b1; waddr = AW'(i); wdata = $urandom; wstrb = 4'hF;
            model[i] = wdata;
            cycle();
        end
        idle();
        test_read_all("b2b");
    endtask

    task automatic test_clr();
        int n;
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            wen = 1'b1; waddr = AW'(i); wdata = $urandom; wstrb = 4'hF;
            model[i] = wdata;
            cycle();
        end
        wen = 1'b1; waddr = 4'd0; wdata = 32'h0BADF00D;
        ren = 1'b1; raddr = 4'd1;
        clr = 1'b1;
        cycle();
        modelRdata = model[1];
        idle();
        vectors++;
        if (rvalid !== 1'b1 || rdata !== modelRdata || ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL clr_cycle_read: got rvalid=%b rdata=%h ready=%b expected 1 %h 0", rvalid, rdata, ready, modelRdata);
        end
        n = 0;
        while (!ready && n < 100) begin
            wen = 1'b1; ren = 1'b1; waddr = AW'($urandom); raddr = AW'($urandom);
            wdata = $urandom; wstrb = 4'hF;
            cycle();
            n++;
            vectors++;
            if (rvalid !== 1'b0 || rdata !== modelRdata) begin
                miscompares++;
                $display("[TB] FAIL clr_init_quiet_%0d: got rvalid=%b rdata=%h expected 0 %h", n, rvalid, rdata, modelRdata);
            end
        end
        idle();
        vectors++;
        if (n != 16) begin miscompares++; $display("[TB] FAIL clr_init_len: got %0d cycles expected 16", n); end
        zeroModel();
        test_read_all("clr_zero");
    endtask

    task automatic test_clr_restart();
        int n;
        idle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        repeat (5) cycle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        countToReady(n);
        vectors++;
        if (n != 16) begin miscompares++; $display("[TB] FAIL clr_restart_len: got %0d cycles expected 16", n); end
        zeroModel();
    endtask

    task automatic test_reset_mid_read();
        int n;
        idle();
        wen = 1'b1; waddr = 4'd7; wdata = 32'h5A5A1234; wstrb = 4'hF;
        model[7] = wdata;
        cycle();
        idle();
        ren = 1'b1; raddr = 4'd7;
        cycle();
        ren = 1'b0;
        vectors++;
        if (rvalid !== 1'b1 || rdata !== 32'h5A5A1234) begin
            miscompares++;
            $display("[TB] FAIL rst_pre_read: got rvalid=%b rdata=%h expected 1 5a5a1234", rvalid, rdata);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_async: got rvalid=%b rdata=%h ready=%b expected 0 0 0", rvalid, rdata, ready);
        end
        for (int i = 0; i < 3; i++) begin
            ren = 1'b1;
            cycle();
            vectors++;
            if (rvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_held_%0d: got rvalid=%b expected 0", i, rvalid); end
        end
        idle();
        rst_n = 1'b1;
        countToReady(n);
        vectors++;
        if (n != 16) begin miscompares++; $display("[TB] FAIL rst_refill_len: got %0d cycles expected 16", n); end
        zeroModel();
        modelRdata = '0;
        test_read_all("rst_zero");
    endtask

    initial begin
`ifdef RAM_FWD_EN
        fwd = 1'b1;
`else
        fwd = 1'b0;
`endif
        rst_n = 1'b0;
        idle();
        waddr = '0;
        raddr = '0;
        wdata = '0;
        test_reset();
        test_read_all("init_zero");
        test_same_addr();
        test_strobe();
        test_random();
        test_back_to_back();
        test_clr();
        test_clr_restart();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
